// File: rtl/hamming_7_4_rx.sv
// hamming_7_4_rx
//   Serial receiver for Hamming(7,4) codewords in the tinyQV user-peripheral
//   slot. Bits are clocked in MSB (r6) first on ui_in. Each 7-bit word is
//   decoded: the syndrome is computed and any single-bit error is corrected.
//   The nibble and its syndrome are then queued in a small FIFO that the CPU
//   reads through the register map.
//
//   Codeword layout {d3,d2,d1,p2,d0,p1,p0} = {r6..r0}, nibble = {r6,r5,r4,r2}.
//
// Ports
//   clk         system clock
//   rst         synchronous, active-high reset
//   ui_in       [0] serial data, [1] bit strobe, [2] frame; [7:3] unused
//   uo_out      [0] FIFO non-empty, [1] overflow sticky; [7:2] zero
//   address     register address
//   data_write  one-cycle write strobe
//   data_in     write data
//   data_out    read data, combinational from address
//
// Register map
//   0x0 R  {1'b0, head_syndrome, head_nibble}, 0x00 when empty
//   0x1 R  {overflow, frame_err, 1'b0, enable, 1'b0, count[2:0]}  W: pop
//   0x2 R  corr_cnt        W: clear
//   0x3 R  frame_err_cnt   W: clear
//   0x4 R  {7'b0, enable}  W: bit0 -> enable, bit1 -> flush FIFO + clear stickies
//
// Handshake: the bus side has no back-pressure. A write is one cycle of
// data_write with address/data_in valid. A pop or flush takes effect on that
// edge, and data_out shows the new head immediately afterwards.

module hamming_7_4_rx #(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [3:0] address,
    input  logic       data_write,
    input  logic [7:0] data_in,
    output logic [7:0] data_out
);

    localparam int              PTR_W   = $clog2(FIFO_DEPTH);
    localparam logic [2:0]      DEPTH_C = 3'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        DECODE = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Input synchroniser and strobe edge detect. The pulse and the data bit
    // are registered together, so they stay aligned for the shift register.
    // ------------------------------------------------------------------
    logic [2:0] sync1, sync2;
    logic       stb_d3, stb_q, data_q;
    logic       frame;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1  <= '0;
            sync2  <= '0;
            stb_d3 <= 1'b0;
            stb_q  <= 1'b0;
            data_q <= 1'b0;
        end else begin
            sync1  <= ui_in[2:0];
            sync2  <= sync1;
            stb_d3 <= sync2[1];
            stb_q  <= sync2[1] & ~stb_d3;
            data_q <= sync2[0];
        end
    end

    assign frame = sync2[2];

    // ------------------------------------------------------------------
    // Control/status registers shared by the FSM and the FIFO
    // ------------------------------------------------------------------
    logic enable;
    logic wr_pop, wr_clr_corr, wr_clr_ferr, wr_ctrl, flush;

    assign wr_pop      = data_write && (address == 4'h1);
    assign wr_clr_corr = data_write && (address == 4'h2);
    assign wr_clr_ferr = data_write && (address == 4'h3);
    assign wr_ctrl     = data_write && (address == 4'h4);
    assign flush       = wr_ctrl && data_in[1];

    // ------------------------------------------------------------------
    // Deserialiser FSM
    // ------------------------------------------------------------------
    state_t     state;
    logic [2:0] bitcnt;
    logic [6:0] shift_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            bitcnt    <= 3'd0;
            shift_reg <= 7'd0;
        end else begin
            case (state)
                IDLE: begin
                    bitcnt <= 3'd0;
                    if (enable && frame) state <= SHIFT;
                end
                SHIFT: begin
                    if (!enable || !frame) begin
                        state  <= IDLE;
                        bitcnt <= 3'd0;
                    end else if (stb_q) begin
                        shift_reg <= {shift_reg[5:0], data_q};
                        if (bitcnt == 3'd6) begin
                            state  <= DECODE;
                            bitcnt <= 3'd0;
                        end else begin
                            bitcnt <= bitcnt + 3'd1;
                        end
                    end
                end
                DECODE: begin
                    if (!enable || !frame) begin
                        state <= IDLE;
                    end else begin
                        state <= SHIFT;
                        // A strobe landing here starts the next word.
                        if (stb_q) begin
                            shift_reg <= {shift_reg[5:0], data_q};
                            bitcnt    <= 3'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Frame dropped part-way through a word. A disable takes priority and
    // aborts silently.
    logic ferr_evt;
    assign ferr_evt = (state == SHIFT) && enable && !frame && (bitcnt != 3'd0);

    // ------------------------------------------------------------------
    // Syndrome and single-bit correction
    // ------------------------------------------------------------------
    logic [2:0] syndrome;
    logic [6:0] flip_mask, corrected;
    logic [6:0] entry;

    always_comb begin
        syndrome[0] = shift_reg[0] ^ shift_reg[2] ^ shift_reg[4] ^ shift_reg[6];
        syndrome[1] = shift_reg[1] ^ shift_reg[2] ^ shift_reg[5] ^ shift_reg[6];
        syndrome[2] = shift_reg[3] ^ shift_reg[4] ^ shift_reg[5] ^ shift_reg[6];
        flip_mask   = 7'd0;
        if (syndrome != 3'd0) flip_mask = 7'd1 << (syndrome - 3'd1);
        corrected   = shift_reg ^ flip_mask;
        entry       = {syndrome, corrected[6], corrected[5], corrected[4], corrected[2]};
    end

    // ------------------------------------------------------------------
    // Decoded-nibble FIFO
    // ------------------------------------------------------------------
    logic [6:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [2:0]       count;
    logic             overflow;
    logic             push_req, pop, full, push_ok, ovf_evt;

    assign push_req = (state == DECODE);
    assign full     = (count == DEPTH_C);
    assign pop      = wr_pop && (count != 3'd0);
    // A pop in the same cycle makes room for an otherwise-dropped push.
    assign push_ok  = push_req && (!full || pop) && !flush;
    assign ovf_evt  = push_req && full && !pop && !flush;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= 3'd0;
            overflow <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= 7'd0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= entry;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_ok, pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
            if (ovf_evt) overflow <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Enable, frame-error sticky and saturating event counters
    // ------------------------------------------------------------------
    logic             frame_err;
    logic [CNT_W-1:0] corr_cnt, ferr_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            enable    <= 1'b0;
            frame_err <= 1'b0;
            corr_cnt  <= '0;
            ferr_cnt  <= '0;
        end else begin
            if (wr_ctrl) enable <= data_in[0];

            if (flush)         frame_err <= 1'b0;
            else if (ferr_evt) frame_err <= 1'b1;

            if (wr_clr_corr)
                corr_cnt <= '0;
            else if (push_ok && (syndrome != 3'd0) && (corr_cnt != CNT_MAX))
                corr_cnt <= corr_cnt + 1'b1;

            if (wr_clr_ferr)
                ferr_cnt <= '0;
            else if (ferr_evt && (ferr_cnt != CNT_MAX))
                ferr_cnt <= ferr_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Read mux and pin outputs
    // ------------------------------------------------------------------
    always_comb begin
        data_out = 8'h00;
        case (address)
            4'h0: if (count != 3'd0) data_out = {1'b0, mem[rd_ptr]};
            4'h1: data_out = {overflow, frame_err, 1'b0, enable, 1'b0, count};
            4'h2: data_out = 8'(corr_cnt);
            4'h3: data_out = 8'(ferr_cnt);
            4'h4: data_out = {7'b0, enable};
            default: data_out = 8'h00;
        endcase
    end

    assign uo_out = {6'b0, overflow, (count != 3'd0)};

    logic unused_bits;
    assign unused_bits = &{1'b0, ui_in[7:3], data_in[7:2]};

endmodule

// File: tb/tb_hamming_7_4_rx.sv
// Testbench for hamming_7_4_rx.
// The reference model decodes with the positional Hamming property: the
// syndrome is the XOR of the 1-based positions of all set bits. It keeps the
// FIFO as a queue of expected entries and the register state as plain
// variables. A compare process checks data_out and uo_out every cycle while
// the model is in step with the design.

module tb_hamming_7_4_rx;

    localparam int DEPTH   = 4;
    localparam int CNT_W   = 3;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic       clk;
    logic       rst;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [3:0] address;
    logic       data_write;
    logic [7:0] data_in;
    logic [7:0] data_out;

    hamming_7_4_rx #(.FIFO_DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .ui_in      (ui_in),
        .uo_out     (uo_out),
        .address    (address),
        .data_write (data_write),
        .data_in    (data_in),
        .data_out   (data_out)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- scoreboard / model ----------------
    logic [6:0] exp_q[$];
    logic       m_ovf, m_ferr, m_en;
    int         m_corr, m_fcnt;
    logic       settled;
    int         n_vec, n_err;

    function automatic logic [6:0] model_decode(input logic [6:0] r);
        logic [2:0] syn;
        logic [6:0] c;
        syn = 3'd0;
        for (int i = 0; i < 7; i++) if (r[i]) syn = syn ^ 3'(i + 1);
        c = r;
        if (syn != 3'd0) c[syn - 3'd1] = ~c[syn - 3'd1];
        return {syn, c[6], c[5], c[4], c[2]};
    endfunction

    function automatic logic [7:0] model_reg(input logic [3:0] a);
        case (a)
            4'h0: return (exp_q.size() == 0) ? 8'h00 : {1'b0, exp_q[0]};
            4'h1: return {m_ovf, m_ferr, 1'b0, m_en, 1'b0, 3'(exp_q.size())};
            4'h2: return 8'(m_corr);
            4'h3: return 8'(m_fcnt);
            4'h4: return {7'b0, m_en};
            default: return 8'h00;
        endcase
    endfunction

    task automatic model_reset();
        exp_q.delete();
        m_ovf = 1'b0; m_ferr = 1'b0; m_en = 1'b0;
        m_corr = 0; m_fcnt = 0;
    endtask

    task automatic model_push(input logic [6:0] cw);
        logic [6:0] e;
        e = model_decode(cw);
        if (exp_q.size() < DEPTH) begin
            exp_q.push_back(e);
            if (e[6:4] != 3'd0 && m_corr < CNT_MAX) m_corr++;
        end else begin
            m_ovf = 1'b1;
        end
    endtask

    task automatic model_write(input logic [3:0] a, input logic [7:0] d);
        case (a)
            4'h1: if (exp_q.size() > 0) void'(exp_q.pop_front());
            4'h2: m_corr = 0;
            4'h3: m_fcnt = 0;
            4'h4: begin
                m_en = d[0];
                if (d[1]) begin
                    exp_q.delete();
                    m_ovf  = 1'b0;
                    m_ferr = 1'b0;
                end
            end
            default: ;
        endcase
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%02h, expected 0x%02h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Compare process: every cycle the model is in step.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (settled) begin
                check($sformatf("reg_0x%0h", address), data_out, model_reg(address));
                check("uo_out", uo_out, {6'b0, m_ovf, (exp_q.size() != 0)});
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic reg_write(input logic [3:0] a, input logic [7:0] d);
        @(negedge clk);
        settled    = 1'b0;
        address    = a;
        data_in    = d;
        data_write = 1'b1;
        @(negedge clk);
        data_write = 1'b0;
        model_write(a, d);
        settled    = 1'b1;
    endtask

    task automatic check_reg(input string name, input logic [3:0] a, input logic [7:0] exp);
        @(negedge clk);
        address = a;
        #1;
        check(name, data_out, exp);
    endtask

    task automatic sweep();
        for (int a = 0; a < 16; a++) begin
            @(negedge clk);
            address = 4'(a);
        end
        @(negedge clk);
    endtask

    task automatic set_frame(input logic v);
        @(negedge clk);
        ui_in[2] = v;
        repeat (4) @(negedge clk);
    endtask

    // Strobe high for one cycle, low for gap cycles.
    task automatic send_bit(input logic b, input int gap);
        @(negedge clk);
        ui_in[0] = b;
        ui_in[1] = 1'b1;
        @(negedge clk);
        ui_in[1] = 1'b0;
        repeat (gap - 1) @(negedge clk);
    endtask

    // mode 0: plain. mode 1: check push latency on reg 0x1.
    // mode 2: issue a pop in the same cycle as the push.
    task automatic send_word(input logic [6:0] cw, input int gap, input int mode);
        settled = 1'b0;
        if (mode == 1) address = 4'h1;
        for (int i = 6; i >= 1; i--) send_bit(cw[i], gap);
        @(negedge clk);
        ui_in[0] = cw[0];
        ui_in[1] = 1'b1;
        @(posedge clk);            // edge that first samples the 7th strobe
        @(negedge clk);
        ui_in[1] = 1'b0;
        repeat (3) @(posedge clk);
        if (mode == 1) begin
            #1;
            check("latency_pre", {5'b0, data_out[2:0]}, 8'(exp_q.size()));
        end
        if (mode == 2) begin
            @(negedge clk);
            address    = 4'h1;
            data_write = 1'b1;
        end
        @(posedge clk);            // 4th edge: push lands
        if (mode == 1) begin
            #1;
            check("latency_post", {5'b0, data_out[2:0]}, 8'(exp_q.size() + 1));
        end
        if (mode == 2) begin
            @(negedge clk);
            data_write = 1'b0;
        end
    endtask

    task automatic word(input logic [6:0] cw, input int gap);
        send_word(cw, gap, 0);
        @(negedge clk);
        model_push(cw);
        settled = 1'b1;
    endtask

    task automatic drain();
        while (exp_q.size() > 0) begin
            check_reg("drain_head", 4'h0, model_reg(4'h0));
            reg_write(4'h1, 8'h00);
        end
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        n_err++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [6:0] cw;
        n_vec = 0; n_err = 0; settled = 1'b0;
        rst = 1'b1; ui_in = 8'h00; address = 4'h0; data_write = 1'b0; data_in = 8'h00;
        model_reset();

        // model pins against hand-derived values
        check("model_pin_clean", {1'b0, model_decode(7'h55)}, 8'h0B);
        check("model_pin_err2",  {1'b0, model_decode(7'h51)}, 8'h3B);
        check("model_pin_ones",  {1'b0, model_decode(7'h7F)}, 8'h0F);

        repeat (3) @(negedge clk);
        settled = 1'b1;
        sweep();                    // in reset
        rst = 1'b0;
        sweep();                    // after release

        reg_write(4'h4, 8'h01);
        set_frame(1'b1);

        // clean word with latency check
        send_word(7'h55, 1, 1);
        @(negedge clk);
        model_push(7'h55);
        settled = 1'b1;
        check_reg("clean_head", 4'h0, 8'h0B);
        check_reg("clean_corr", 4'h2, 8'h00);
        check("clean_uo", uo_out, 8'h01);
        drain();

        // single-bit errors at every position
        for (int pos = 0; pos < 7; pos++) begin
            cw = 7'h55 ^ (7'd1 << pos);
            word(cw, 1);
            check_reg("err_head", 4'h0, {1'b0, 3'(pos + 1), 4'hB});
            if (pos == 0) check_reg("err_corr1", 4'h2, 8'h01);
            if (pos == 2) check_reg("err_pos2", 4'h0, 8'h3B);
            sweep();
            drain();
        end

        // frame error after 4 strobes
        settled = 1'b0;
        for (int i = 0; i < 4; i++) send_bit(1'b1, 1);
        repeat (6) @(negedge clk);
        ui_in[2] = 1'b0;
        repeat (4) @(negedge clk);
        m_ferr = 1'b1;
        if (m_fcnt < CNT_MAX) m_fcnt++;
        settled = 1'b1;
        check_reg("ferr_status", 4'h1, 8'h50);
        check_reg("ferr_cnt", 4'h3, 8'h01);
        set_frame(1'b1);
        word(7'h55, 2);
        check_reg("ferr_next", 4'h0, 8'h0B);
        drain();

        // disabling mid-word aborts without a frame error
        settled = 1'b0;
        for (int i = 0; i < 3; i++) send_bit(1'b0, 1);
        reg_write(4'h4, 8'h00);
        repeat (4) @(negedge clk);
        reg_write(4'h4, 8'h01);
        word(7'h2A, 1);
        sweep();
        drain();

        // overflow: 5 words into 4 entries
        word(7'h55, 1);
        for (int i = 0; i < 4; i++) word(7'($urandom_range(0, 127)), 1);
        check_reg("ovf_status", 4'h1, 8'hD4);
        check_reg("ovf_head", 4'h0, 8'h0B);
        reg_write(4'h1, 8'h00);
        reg_write(4'h1, 8'h00);

        // flush with 2 queued
        reg_write(4'h4, 8'h03);
        check_reg("flush_status", 4'h1, 8'h10);
        check_reg("flush_en", 4'h4, 8'h01);

        // push coincident with pop on a full FIFO
        for (int i = 0; i < 4; i++) word(7'($urandom_range(0, 127)), 1);
        cw = 7'($urandom_range(0, 127));
        send_word(cw, 1, 2);
        @(negedge clk);
        void'(exp_q.pop_front());
        model_push(cw);
        settled = 1'b1;
        check_reg("coinc_status", 4'h1, 8'h14);
        sweep();
        drain();

        // streaming: 3 back-to-back words, minimum spacing
        settled = 1'b0;
        for (int i = 6; i >= 0; i--) send_bit(7'h55 >> i, 1);
        for (int i = 6; i >= 0; i--) send_bit(7'h7F >> i, 1);
        for (int i = 6; i >= 0; i--) send_bit(7'h51 >> i, 1);
        repeat (6) @(negedge clk);
        model_push(7'h55);
        model_push(7'h7F);
        model_push(7'h51);
        settled = 1'b1;
        check_reg("stream_0", 4'h0, 8'h0B);
        reg_write(4'h1, 8'h00);
        check_reg("stream_1", 4'h0, 8'h0F);
        reg_write(4'h1, 8'h00);
        check_reg("stream_2", 4'h0, 8'h3B);
        reg_write(4'h1, 8'h00);
        check_reg("stream_empty", 4'h0, 8'h00);

        // randomized words, gaps and pops
        for (int n = 0; n < 24; n++) begin
            word(7'($urandom_range(0, 127)), $urandom_range(1, 3));
            if ($urandom_range(0, 1) == 1) reg_write(4'h1, 8'($urandom));
            if ((n % 6) == 5) sweep();
        end
        reg_write(4'h2, 8'h00);
        reg_write(4'h3, 8'h00);
        sweep();
        drain();

        // reset in the middle of a word
        settled = 1'b0;
        for (int i = 0; i < 3; i++) send_bit(1'b1, 1);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        model_reset();
        rst = 1'b0;
        settled = 1'b1;
        sweep();
        check_reg("rst_status", 4'h1, 8'h00);
        check("rst_uo", uo_out, 8'h00);
        reg_write(4'h4, 8'h01);
        repeat (3) @(negedge clk);
        word(7'h55, 1);
        check_reg("rst_next", 4'h0, 8'h0B);
        sweep();

        settled = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
